// File: rtl/result_ascii_formatter.sv
// Latches an unsigned value, converts it to BCD with a fixed-latency double-dabble and
// streams it out as ASCII digits (leading zeros suppressed) plus an optional terminator.
module result_ascii_formatter #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DIGITS          = 5,
  parameter int unsigned EMIT_TERMINATOR = 1,
  parameter logic [7:0]  TERMINATOR      = 8'h0A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  output logic             busy,
  output logic [7:0]       character,
  output logic             enable_character,
  input  logic             char_ready
);

  localparam int unsigned PtrW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StConvert, StEmit, StTerm} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [7:0]        char_q, char_d;
  logic              en_q, en_d;

  logic [BcdW-1:0]   bcd_adj, bcd_step;
  logic [WIDTH-1:0]  bin_step;
  logic [PtrW-1:0]   msd, ptr_dec;
  logic [3:0]        first_nib, next_nib;

  // One double-dabble step: correct nibbles >= 5, then shift the whole {bcd,bin} pair.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
    {bcd_step, bin_step} = {bcd_adj, bin_q} << 1;
  end

  // Most significant nonzero digit of the finished result; defaults to digit 0 so 0 prints "0".
  always_comb begin
    msd       = '0;
    first_nib = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_step[4*i +: 4] != 4'd0) msd = PtrW'(i);
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (PtrW'(i) == msd) first_nib = bcd_step[4*i +: 4];
    end
  end

  always_comb begin
    ptr_dec  = ptr_q - 1'b1;
    next_nib = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (PtrW'(i) == ptr_dec) next_nib = bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ptr_d   = ptr_q;
    char_d  = char_q;
    en_d    = en_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        bcd_d = bcd_step;
        bin_d = bin_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StEmit;
          ptr_d   = msd;
          char_d  = 8'h30 + {4'h0, first_nib};
          en_d    = 1'b1;
        end
      end
      StEmit: begin
        if (char_ready) begin
          if (ptr_q == '0) begin
            if (EMIT_TERMINATOR != 0) begin
              state_d = StTerm;
              char_d  = TERMINATOR;
            end else begin
              state_d = StIdle;
              char_d  = 8'h00;
              en_d    = 1'b0;
            end
          end else begin
            ptr_d  = ptr_dec;
            char_d = 8'h30 + {4'h0, next_nib};
          end
        end
      end
      StTerm: begin
        if (char_ready) begin
          state_d = StIdle;
          char_d  = 8'h00;
          en_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ptr_q   <= '0;
      char_q  <= 8'h00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ptr_q   <= ptr_d;
      char_q  <= char_d;
      en_q    <= en_d;
    end
  end

  assign busy             = (state_q != StIdle);
  assign character        = char_q;
  assign enable_character = en_q;

endmodule

// File: tb/tb_result_ascii_formatter.sv
// Directed bench for result_ascii_formatter: expected characters are queued at start and
// popped on every transfer; stalls, latency and idle outputs are checked along the way.
module tb_result_ascii_formatter;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] value;
  logic             start;
  logic             busy;
  logic [7:0]       character;
  logic             enable_character;
  logic             char_ready;

  result_ascii_formatter #(
    .WIDTH          (WIDTH),
    .DIGITS         (5),
    .EMIT_TERMINATOR(1),
    .TERMINATOR     (8'h0A)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .value           (value),
    .start           (start),
    .busy            (busy),
    .character       (character),
    .enable_character(enable_character),
    .char_ready      (char_ready)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         start_cyc = 0;
  logic       awaiting_first = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain decimal conversion by division, then the terminator.
  task automatic push_expected(input int unsigned v);
    logic [7:0]  digs[$];
    int unsigned x;
    x = v;
    if (x == 0) digs.push_back(8'h30);
    while (x != 0) begin
      digs.push_front(8'(8'h30 + (x % 10)));
      x = x / 10;
    end
    foreach (digs[i]) exp_q.push_back(digs[i]);
    exp_q.push_back(8'h0A);
  endtask

  // Sample on the falling edge, then advance one rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (prev_stall)
      check("stall_hold", {23'b0, enable_character, character}, {23'b0, 1'b1, prev_char});
    if (awaiting_first && enable_character) begin
      check("first_latency", 32'(cyc - start_cyc - 1), WIDTH);
      awaiting_first = 1'b0;
    end
    if (enable_character === 1'b0) check("idle_char_zero", {24'b0, character}, 32'h0);
    if (enable_character === 1'b1 && char_ready) begin
      check("char_expected", {31'b0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("char_value", {24'b0, character}, {24'b0, e});
      end
    end
    prev_stall = (enable_character === 1'b1) && !char_ready;
    prev_char  = character;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_start(input int unsigned v);
    value          = WIDTH'(v);
    start          = 1'b1;
    start_cyc      = cyc;
    awaiting_first = 1'b1;
    push_expected(v);
    tick();
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'h1);
  endtask

  task automatic wait_emit();
    int n = 0;
    while (enable_character !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("reach_emit", {31'b0, enable_character}, 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain_bound", {31'b0, n < 200}, 32'h1);
    check("done_busy", {31'b0, busy}, 32'h0);
    check("done_enable", {31'b0, enable_character}, 32'h0);
    check("done_char", {24'b0, character}, 32'h0);
    check("done_queue", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    char_ready = 1'b1;
    value      = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_enable", {31'b0, enable_character}, 32'h0);
    check("reset_char", {24'b0, character}, 32'h0);

    do_start(1021);
    drain();
    do_start(0);
    drain();
    do_start(65535);
    drain();
    do_start(100);
    drain();

    // Stall three cycles while '0' is presented.
    do_start(1021);
    wait_emit();
    tick();
    check("stall_char", {24'b0, character}, 32'h30);
    char_ready = 1'b0;
    repeat (3) tick();
    char_ready = 1'b1;
    drain();

    // A start during conversion must be ignored.
    do_start(7);
    repeat (3) tick();
    value = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // Reset mid-emission aborts the operation.
    do_start(1021);
    wait_emit();
    tick();
    char_ready = 1'b0;
    rst        = 1'b1;
    tick();
    rst            = 1'b0;
    char_ready     = 1'b1;
    prev_stall     = 1'b0;
    awaiting_first = 1'b0;
    exp_q.delete();
    check("abort_enable", {31'b0, enable_character}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_char", {24'b0, character}, 32'h0);
    repeat (3) tick();
    do_start(42);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
